// File: rtl/doubleadd_pkg.sv
// ----------------------------------------------------------------------------
// doubleadd_pkg
//   Shared definitions for the double-adder datapath.
//   - TAG                    : width of the opaque destination tag
//   - DOUBLEADD_ISSUE_DEPTH  : default issue-queue depth (power of two, >= 2)
//   - doubleadd_issue_entry  : one queued operand packet
// ----------------------------------------------------------------------------
package doubleadd_pkg;

    localparam int TAG                   = 8;
    localparam int DOUBLEADD_ISSUE_DEPTH = 4;

    typedef struct packed {
        logic [63:0]    a;
        logic [63:0]    b;
        logic [TAG-1:0] tag;
        logic [63:0]    mult_operand;
    } doubleadd_issue_entry;

endpackage : doubleadd_pkg

// File: rtl/doubleadd_issue_queue.sv
// ----------------------------------------------------------------------------
// doubleadd_issue_queue
//   Operand issue queue in front of the double-adder unpack stage. Buffers
//   (a, b, tag, mult_operand) packets from the PE datapath in a circular
//   buffer and presents the head packet with a valid bit, holding it steady
//   while the adder's normalise stages stall. Producers see valid/ready.
//
//   Optional feature (macro DOUBLEADD_ISSUE_BYPASS_EN):
//     defined   - an empty, unstalled, unsquashed queue forwards in_* straight
//                 to out_* in the same cycle without storing the packet.
//     undefined - no bypass; enqueue-to-out_valid latency is always >= 1.
//
// Ports
//   clock             in   1      rising-edge clock
//   reset             in   1      synchronous, active-high
//   in_valid          in   1      producer has a packet
//   in_ready          out  1      queue accepts this cycle (not full)
//   in_a / in_b       in   64     IEEE-754 double operands
//   in_tag            in   TAG    opaque destination tag
//   in_mult_operand   in   64     passenger operand, forwarded untouched
//   squash            in   1      discard every queued packet
//   adder_stall       in   1      OR of normalise1/normalise2 stall_out
//   out_valid         out  1      head packet valid (to unpack.valid)
//   out_a / out_b     out  64     head operands, zero when not valid
//   out_tag           out  TAG    head tag, zero when not valid
//   out_mult_operand  out  64     head passenger, zero when not valid
//   occupancy         out  CNT_W  entries held, 0..DEPTH
// ----------------------------------------------------------------------------
module doubleadd_issue_queue
    import doubleadd_pkg::*;
#(
    parameter  int DEPTH = DOUBLEADD_ISSUE_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG-1:0]   in_tag,
    input  logic [63:0]      in_mult_operand,
    input  logic             squash,
    input  logic             adder_stall,
    output logic             out_valid,
    output logic [63:0]      out_a,
    output logic [63:0]      out_b,
    output logic [TAG-1:0]   out_tag,
    output logic [63:0]      out_mult_operand,
    output logic [CNT_W-1:0] occupancy
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    doubleadd_issue_entry mem [DEPTH];
    doubleadd_issue_entry head_entry;

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count;
    logic             not_empty;
    logic             bypass;
    logic             enq;
    logic             deq;

    assign not_empty = (count != '0);
    // Full is judged on the registered count only; a same-cycle pop does not
    // open a slot, which keeps in_ready off the adder_stall timing path.
    assign in_ready  = (count != FULL_CNT);
    assign occupancy = count;

`ifdef DOUBLEADD_ISSUE_BYPASS_EN
    assign bypass = ~not_empty & in_valid & ~adder_stall & ~squash;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed packet goes straight to the adder and is never written.
    assign enq = in_valid & in_ready & ~squash & ~bypass;
    // Only stored packets are popped; a bypassed one never touched storage.
    assign deq = not_empty & ~adder_stall;

    // Pointer and occupancy state. Reset outranks squash.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (squash) begin
            // The squash cycle drops the incoming packet and counts no pop.
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (enq) tail_ptr <= tail_ptr + 1'b1;
            if (deq) head_ptr <= head_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Packet storage. Pointers wrap naturally because DEPTH is a power of two.
    // NOTE: the storage array is deliberately not reset; occupancy alone says
    // which entries are live, and leaving it out keeps the array a plain RAM.
    always_ff @(posedge clock) begin
        if (enq) begin
            mem[tail_ptr] <= '{a:            in_a,
                               b:            in_b,
                               tag:          in_tag,
                               mult_operand: in_mult_operand};
        end
    end

    assign head_entry = mem[head_ptr];

    // Output mux: head entry, bypassed input, or the all-zero bubble that
    // unpack itself produces when idle.
    // NOTE: every output gets a default before the branches so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        out_valid        = 1'b0;
        out_a            = '0;
        out_b            = '0;
        out_tag          = '0;
        out_mult_operand = '0;
        if (not_empty) begin
            out_valid        = 1'b1;
            out_a            = head_entry.a;
            out_b            = head_entry.b;
            out_tag          = head_entry.tag;
            out_mult_operand = head_entry.mult_operand;
        end else if (bypass) begin
            out_valid        = 1'b1;
            out_a            = in_a;
            out_b            = in_b;
            out_tag          = in_tag;
            out_mult_operand = in_mult_operand;
        end
    end

endmodule : doubleadd_issue_queue

// File: tb/tb_doubleadd_issue_queue.sv
// ----------------------------------------------------------------------------
// tb_doubleadd_issue_queue
//   Self-checking bench for doubleadd_issue_queue (DEPTH = 4). Inputs change on
//   the falling edge and outputs are sampled 2 ns later, well before the next
//   rising edge. Packet data is derived from the tag so a tag alone determines
//   the expected operands.
// ----------------------------------------------------------------------------
module tb_doubleadd_issue_queue;
    import doubleadd_pkg::*;

    localparam int CNT_W = $clog2(DOUBLEADD_ISSUE_DEPTH) + 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG-1:0]   in_tag;
    logic [63:0]      in_mult_operand;
    logic             squash;
    logic             adder_stall;
    logic             out_valid;
    logic [63:0]      out_a;
    logic [63:0]      out_b;
    logic [TAG-1:0]   out_tag;
    logic [63:0]      out_mult_operand;
    logic [CNT_W-1:0] occupancy;

    int total = 0;
    int bad   = 0;

    doubleadd_issue_queue dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_tag           (in_tag),
        .in_mult_operand  (in_mult_operand),
        .squash           (squash),
        .adder_stall      (adder_stall),
        .out_valid        (out_valid),
        .out_a            (out_a),
        .out_b            (out_b),
        .out_tag          (out_tag),
        .out_mult_operand (out_mult_operand),
        .occupancy        (occupancy)
    );

    always #5 clock = ~clock;

    // Operand values derived from a tag; tag 5 on test 1 gives 1.0 and 2.0.
    function automatic logic [63:0] pa(input int t);
        return 64'h3FF0_0000_0000_0000 + 64'(t) - 64'd5;
    endfunction
    function automatic logic [63:0] pb(input int t);
        return 64'h4000_0000_0000_0000 + 64'(t) - 64'd5;
    endfunction
    function automatic logic [63:0] pm(input int t);
        return ~pa(t);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int t, input logic sq, input logic st);
        in_valid        = v;
        in_tag          = TAG'(t);
        in_a            = pa(t);
        in_b            = pb(t);
        in_mult_operand = pm(t);
        squash          = sq;
        adder_stall     = st;
    endtask

    // Checks the full output bundle against a packet tag (or the zero bubble).
    task automatic expect_out(input string name, input logic ev, input int et,
                              input int eocc, input logic erdy);
        check({name, " out_valid"}, 64'(out_valid), 64'(ev));
        check({name, " out_tag"},   64'(out_tag),   ev ? 64'(TAG'(et)) : 64'd0);
        check({name, " out_a"},     out_a,          ev ? pa(et) : 64'd0);
        check({name, " out_b"},     out_b,          ev ? pb(et) : 64'd0);
        check({name, " out_mult"},  out_mult_operand, ev ? pm(et) : 64'd0);
        check({name, " occupancy"}, 64'(occupancy), 64'(eocc));
        check({name, " in_ready"},  64'(in_ready),  64'(erdy));
    endtask

    typedef struct {
        logic v;     // in_valid
        int   tag;   // in_tag
        logic sq;    // squash
        logic st;    // adder_stall
        logic eov;   // expected out_valid (state before this cycle's edge)
        int   etag;  // expected head tag
        int   eocc;  // expected occupancy
        logic erdy;  // expected in_ready
    } vec_t;

    vec_t vq[$];

    initial begin
        int sent;
        int recv;
        int cyc;

        // Pushes into an empty queue carry stall=1 so the table holds with or
        // without the bypass build.
        //              v   tag sq  st  eov etag occ rdy
        // test 1: single push, pop
        vq.push_back('{1'b1,  5, 1'b0, 1'b1, 1'b0,  0, 0, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b1,  5, 1, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 0, 1'b1});
        // test 2: stalled pushes fill the queue, head held stable
        vq.push_back('{1'b1,  1, 1'b0, 1'b1, 1'b0,  0, 0, 1'b1});
        vq.push_back('{1'b1,  2, 1'b0, 1'b1, 1'b1,  1, 1, 1'b1});
        vq.push_back('{1'b1,  3, 1'b0, 1'b1, 1'b1,  1, 2, 1'b1});
        vq.push_back('{1'b1,  4, 1'b0, 1'b1, 1'b1,  1, 3, 1'b1});
        vq.push_back('{1'b1,  5, 1'b0, 1'b1, 1'b1,  1, 4, 1'b0});
        vq.push_back('{1'b1,  5, 1'b0, 1'b1, 1'b1,  1, 4, 1'b0});
        // test 3: stall drops while full; pop first, 5th accepted next cycle
        vq.push_back('{1'b1,  5, 1'b0, 1'b0, 1'b1,  1, 4, 1'b0});
        vq.push_back('{1'b1,  5, 1'b0, 1'b0, 1'b1,  2, 3, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b1,  3, 3, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b1,  4, 2, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b1,  5, 1, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 0, 1'b1});
        // test 5: squash at occupancy 3 with in_valid high
        vq.push_back('{1'b1,  6, 1'b0, 1'b1, 1'b0,  0, 0, 1'b1});
        vq.push_back('{1'b1,  7, 1'b0, 1'b1, 1'b1,  6, 1, 1'b1});
        vq.push_back('{1'b1,  8, 1'b0, 1'b1, 1'b1,  6, 2, 1'b1});
        vq.push_back('{1'b1,  9, 1'b1, 1'b1, 1'b1,  6, 3, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 0, 1'b1});
        // pointers restart at 0 after squash
        vq.push_back('{1'b1, 10, 1'b0, 1'b1, 1'b0,  0, 0, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b1, 10, 1, 1'b1});
        vq.push_back('{1'b0,  0, 1'b0, 1'b0, 1'b0,  0, 0, 1'b1});

        // Reset: pointers and occupancy cleared
        reset = 1'b1;
        drive(1'b0, 0, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #2;
        expect_out("reset", 1'b0, 0, 0, 1'b1);

        // Table-driven tests 1, 2, 3, 5
        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clock);
            drive(vq[i].v, vq[i].tag, vq[i].sq, vq[i].st);
            #2;
            expect_out($sformatf("vec%0d", i), vq[i].eov, vq[i].etag, vq[i].eocc, vq[i].erdy);
        end

        // Latency from an empty queue with stall low
        @(negedge clock);
        drive(1'b1, 20, 1'b0, 1'b0);
        #2;
`ifdef DOUBLEADD_ISSUE_BYPASS_EN
        expect_out("bypass same cycle", 1'b1, 20, 0, 1'b1);
        @(negedge clock);
        drive(1'b0, 0, 1'b0, 1'b0);
        #2;
        expect_out("bypass not stored", 1'b0, 0, 0, 1'b1);
        @(negedge clock);
        drive(1'b1, 21, 1'b0, 1'b1);
        #2;
        expect_out("stall blocks bypass", 1'b0, 0, 0, 1'b1);
        @(negedge clock);
        drive(1'b0, 0, 1'b0, 1'b0);
        #2;
        expect_out("stalled pkt queued", 1'b1, 21, 1, 1'b1);
`else
        expect_out("no bypass", 1'b0, 0, 0, 1'b1);
        @(negedge clock);
        drive(1'b0, 0, 1'b0, 1'b0);
        #2;
        expect_out("latency one", 1'b1, 20, 1, 1'b1);
`endif
        @(negedge clock);
        #2;
        expect_out("drained", 1'b0, 0, 0, 1'b1);

        // Test 4: stream tags 0..9 through the queue with random stall
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 10 && cyc < 300) begin
            @(negedge clock);
            drive(sent < 10, sent, 1'b0, 1'($urandom_range(0, 1)));
            #2;
            if (out_valid && !adder_stall) begin
                check($sformatf("wrap tag %0d", recv), 64'(out_tag), 64'(TAG'(recv)));
                check($sformatf("wrap a %0d", recv), out_a, pa(recv));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        check("wrap received count", 64'(recv), 64'd10);
        repeat (3) begin
            @(negedge clock);
            drive(1'b0, 0, 1'b0, 1'b0);
            #2;
            expect_out("wrap no duplicate", 1'b0, 0, 0, 1'b1);
        end

        // Reset mid-stall discards the held head packet
        @(negedge clock);
        drive(1'b1, 30, 1'b0, 1'b1);
        @(negedge clock);
        drive(1'b1, 31, 1'b0, 1'b1);
        #2;
        expect_out("pre-reset held", 1'b1, 30, 1, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 32, 1'b0, 1'b1);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b0, 0, 1'b0, 1'b1);
        #2;
        expect_out("reset mid-stall", 1'b0, 0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_doubleadd_issue_queue
